// File: rtl/codec_spi_frame_pkg.sv
// Shared definitions for the codec SPI frame engine: sample width, FSM states
// and a small sizing helper.
package codec_spi_frame_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/codec_spi_frame_sclk_gen.sv
// SCLK half-period divider. Rise/fall strobes flag the clk edge at which the
// registered sclk toggles; the count restarts whenever en is low.
module codec_spi_frame_sclk_gen #(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(HALF_DIV + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          sclk_q;
    logic          tick_s;

    assign tick_s = en && (cnt_q == CNT_LAST);
    assign rise   = tick_s && !sclk_q;
    assign fall   = tick_s && sclk_q;
    assign sclk   = sclk_q;

    // Divider count and sclk level; idle low outside the shift window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (!en) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else if (tick_s) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q  <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/codec_spi_frame.sv
// One full-duplex mode-0 SPI frame per rising edge of adc_clock: sends dac
// MSB first on mosi, captures miso into adc at frame completion.
module codec_spi_frame
    import codec_spi_frame_pkg::*;
#(
    parameter int DATA_W   = SAMPLE_W,
    parameter int HALF_DIV = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adc_clock,
    input  logic [DATA_W-1:0] dac,
    input  logic              miso,
    output logic              mosi,
    output logic              sclk,
    output logic              cs,
    output logic [DATA_W-1:0] adc,
    output logic              adc_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int CNT_W = $clog2(max3(HALF_DIV, CS_SETUP, CS_HOLD) + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

    state_e            state_q;
    logic              req_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BIT_W-1:0]  bit_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] adc_q;
    logic              cs_q;
    logic              mosi_q;
    logic              valid_q;
    logic              busy_q;
    logic              ovr_q;
    logic              start_s;
    logic              rise_s;
    logic              fall_s;

    assign start_s = adc_clock & ~req_q;

    codec_spi_frame_sclk_gen #(.HALF_DIV(HALF_DIV)) u_sclk_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == ST_SHIFT),
        .sclk (sclk),
        .rise (rise_s),
        .fall (fall_s)
    );

    // Frame sequencer; tx_q holds only the bits not yet placed on mosi.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            adc_q   <= '0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            req_q   <= adc_clock;
            valid_q <= 1'b0;
            ovr_q   <= start_s && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        tx_q    <= {dac[DATA_W-2:0], 1'b0};
                        mosi_q  <= dac[DATA_W-1];
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (rise_s) begin
                        rx_q <= {rx_q[DATA_W-2:0], miso};
                    end
                    if (fall_s) begin
                        if (bit_q == BIT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= ST_HOLD;
                        end else begin
                            mosi_q  <= tx_q[DATA_W-1];
                            tx_q    <= {tx_q[DATA_W-2:0], 1'b0};
                            bit_q   <= bit_q + BIT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cs_q    <= 1'b1;
                        adc_q   <= rx_q;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        mosi_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mosi      = mosi_q;
    assign cs        = cs_q;
    assign adc       = adc_q;
    assign adc_valid = valid_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_codec_spi_frame.sv
// Randomised frame-level bench: a codec model serves miso and records mosi on
// sclk rises; expectations come from the frame timing formula and sent words.
module tb_codec_spi_frame;

    localparam int LAT_A = 2 + 2 * 16 * 4 + 2;
    localparam int LAT_B = 1 + 2 * 16 * 1 + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        adc_clock = 1'b0, adc_clock_b = 1'b0;
    logic [15:0] dac = 16'h0000, dac_b = 16'h0000;
    logic        miso, mosi, sclk, cs, adc_valid, busy, overrun;
    logic        miso_b, mosi_b, sclk_b, cs_b, adc_valid_b, busy_b, overrun_b;
    logic [15:0] adc, adc_b;

    logic [15:0] codec_word = 16'h0000, codec_word_b = 16'h0000;
    logic [15:0] mosi_cap = 16'h0000, mosi_cap_b = 16'h0000;
    int          rise_cnt = 0, rise_cnt_b = 0;
    logic [15:0] exp_tx, exp_rx;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    codec_spi_frame dut (
        .clk(clk), .rst(rst), .adc_clock(adc_clock), .dac(dac), .miso(miso),
        .mosi(mosi), .sclk(sclk), .cs(cs), .adc(adc), .adc_valid(adc_valid),
        .busy(busy), .overrun(overrun)
    );

    codec_spi_frame #(.DATA_W(16), .HALF_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .adc_clock(adc_clock_b), .dac(dac_b), .miso(miso_b),
        .mosi(mosi_b), .sclk(sclk_b), .cs(cs_b), .adc(adc_b), .adc_valid(adc_valid_b),
        .busy(busy_b), .overrun(overrun_b)
    );

    // Codec: presents next ADC bit after each rise, records DAC bit on each rise.
    always @(negedge cs or posedge sclk) begin
        if (sclk) begin
            rise_cnt = rise_cnt + 1;
            mosi_cap = {mosi_cap[14:0], mosi};
        end else begin
            rise_cnt = 0;
            mosi_cap = 16'h0000;
        end
    end
    assign miso = (rise_cnt < 16) ? codec_word[15 - rise_cnt] : 1'b0;

    always @(negedge cs_b or posedge sclk_b) begin
        if (sclk_b) begin
            rise_cnt_b = rise_cnt_b + 1;
            mosi_cap_b = {mosi_cap_b[14:0], mosi_b};
        end else begin
            rise_cnt_b = 0;
            mosi_cap_b = 16'h0000;
        end
    end
    assign miso_b = (rise_cnt_b < 16) ? codec_word_b[15 - rise_cnt_b] : 1'b0;

    task automatic kick(input logic [15:0] d, input logic [15:0] c);
        dac = d; codec_word = c; exp_tx = d; exp_rx = c;
        adc_clock = 1'b1;
    endtask

    // Follows one frame from its start edge; k counts cycles after that edge.
    task automatic run_frame(input string name, input int ovr_k, input bit hold_req,
                             input bit chain, input logic [15:0] nd, input logic [15:0] nc);
        logic [15:0] want_tx, want_rx;
        int cs_low, ovr_seen, ovr_at;
        bit done;
        want_tx = exp_tx; want_rx = exp_rx;
        cs_low = 0; ovr_seen = 0; ovr_at = -1; done = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (cs === 1'b0) cs_low++;
            if (overrun === 1'b1) begin ovr_seen++; ovr_at = k; end
            if (k == 0) begin
                n_checks++;
                if (cs !== 1'b0 || busy !== 1'b1)
                    $display("FAIL start_%s cs=%b busy=%b want cs=0 busy=1", name, cs, busy);
                else n_pass++;
            end
            if (k == 3 && !hold_req) adc_clock = 1'b0;
            if (k == 10) dac = 16'($urandom);
            if (k == ovr_k) adc_clock = 1'b1;
            if (k == ovr_k + 2) adc_clock = 1'b0;
            if (adc_valid === 1'b1) begin
                done = 1'b1;
                n_checks++;
                if (k != LAT_A) $display("FAIL latency_%s got %0d want %0d", name, k, LAT_A);
                else n_pass++;
                n_checks++;
                if (adc !== want_rx) $display("FAIL adc_%s got %h want %h", name, adc, want_rx);
                else n_pass++;
                n_checks++;
                if (mosi_cap !== want_tx) $display("FAIL mosi_%s got %h want %h", name, mosi_cap, want_tx);
                else n_pass++;
                n_checks++;
                if (rise_cnt != 16) $display("FAIL rises_%s got %0d want 16", name, rise_cnt);
                else n_pass++;
                n_checks++;
                if (cs_low != LAT_A) $display("FAIL cs_low_%s got %0d want %0d", name, cs_low, LAT_A);
                else n_pass++;
                n_checks++;
                if (busy !== 1'b0 || cs !== 1'b1 || mosi !== 1'b0)
                    $display("FAIL end_%s busy=%b cs=%b mosi=%b want 0 1 0", name, busy, cs, mosi);
                else n_pass++;
                n_checks++;
                if (ovr_k >= 0 && (ovr_seen != 1 || ovr_at != ovr_k + 1))
                    $display("FAIL overrun_%s got %0d pulses at %0d want 1 at %0d", name, ovr_seen, ovr_at, ovr_k + 1);
                else if (ovr_k < 0 && ovr_seen != 0)
                    $display("FAIL overrun_%s got %0d pulses want 0", name, ovr_seen);
                else n_pass++;
                if (chain) kick(nd, nc);
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL timeout_%s got no adc_valid want one at %0d", name, LAT_A);
        end
    endtask

    task automatic idle_check(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            n_checks++;
            if (cs !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0 || adc_valid !== 1'b0 || overrun !== 1'b0)
                $display("FAIL idle_%s cyc %0d got cs=%b sclk=%b busy=%b vld=%b ovr=%b want 1 0 0 0 0",
                         name, i, cs, sclk, busy, adc_valid, overrun);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_checks++;
            if (cs !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 || adc !== 16'h0000 ||
                busy !== 1'b0 || adc_valid !== 1'b0 || overrun !== 1'b0)
                $display("FAIL reset_idle cyc %0d got cs=%b sclk=%b mosi=%b adc=%h busy=%b vld=%b ovr=%b",
                         i, cs, sclk, mosi, adc, busy, adc_valid, overrun);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        kick(16'hA5C3, 16'h3C5A);
        run_frame("basic", -1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            kick(16'($urandom), 16'($urandom));
            run_frame("random", -1, 1'b0, 1'b0, 16'h0000, 16'h0000);
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end
    endtask

    task automatic test_overrun();
        kick(16'($urandom), 16'($urandom));
        run_frame("ovr_mid", 40, 1'b0, 1'b0, 16'h0000, 16'h0000);
        idle_check("after_ovr_mid", 10);
        kick(16'($urandom), 16'($urandom));
        run_frame("ovr_hold", LAT_A - 1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        adc_clock = 1'b0;
        idle_check("after_ovr_hold", 10);
    endtask

    task automatic test_back_to_back();
        kick(16'($urandom), 16'h0001);
        run_frame("b2b_first", -1, 1'b0, 1'b1, 16'($urandom), 16'hFFFF);
        run_frame("b2b_second", -1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        idle_check("after_b2b", 5);
    endtask

    task automatic test_hold_high();
        kick(16'($urandom), 16'($urandom));
        run_frame("held", -1, 1'b1, 1'b0, 16'h0000, 16'h0000);
        idle_check("held_high", 20);
        adc_clock = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        kick(16'($urandom), 16'($urandom));
        @(posedge clk);
        repeat (70) @(negedge clk);
        adc_clock = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || adc !== 16'hFFFF)
            $display("FAIL pre_reset got busy=%b adc=%h want busy=1 adc=ffff", busy, adc);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (cs !== 1'b1 || sclk !== 1'b0 || adc !== 16'h0000 || busy !== 1'b0)
            $display("FAIL async_reset got cs=%b sclk=%b adc=%h busy=%b want 1 0 0000 0", cs, sclk, adc, busy);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        idle_check("after_reset", 3);
        kick(16'($urandom), 16'($urandom));
        run_frame("post_reset", -1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic test_fast_params();
        logic [15:0] words [2];
        int cs_low;
        bit done;
        words[0] = 16'h8001;
        words[1] = 16'($urandom);
        for (int f = 0; f < 2; f++) begin
            @(negedge clk);
            dac_b = words[f]; codec_word_b = 16'($urandom); adc_clock_b = 1'b1;
            cs_low = 0; done = 1'b0;
            @(posedge clk);
            for (int k = 0; k < 100 && !done; k++) begin
                @(negedge clk);
                if (cs_b === 1'b0) cs_low++;
                if (k == 3) adc_clock_b = 1'b0;
                if (adc_valid_b === 1'b1) begin
                    done = 1'b1;
                    n_checks++;
                    if (k != LAT_B) $display("FAIL fast_latency got %0d want %0d", k, LAT_B);
                    else n_pass++;
                    n_checks++;
                    if (adc_b !== codec_word_b) $display("FAIL fast_adc got %h want %h", adc_b, codec_word_b);
                    else n_pass++;
                    n_checks++;
                    if (mosi_cap_b !== words[f] || rise_cnt_b != 16)
                        $display("FAIL fast_mosi got %h/%0d rises want %h/16", mosi_cap_b, rise_cnt_b, words[f]);
                    else n_pass++;
                    n_checks++;
                    if (cs_low != LAT_B || busy_b !== 1'b0 || overrun_b !== 1'b0)
                        $display("FAIL fast_cs got cs_low=%0d busy=%b ovr=%b want %0d 0 0", cs_low, busy_b, overrun_b, LAT_B);
                    else n_pass++;
                end
            end
            if (!done) begin
                n_checks++;
                $display("FAIL fast_timeout got no adc_valid want one at %0d", LAT_B);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_hold_high();
        test_fast_params();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
